// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN types and constants for tile split/merge blocks
package cnn_pkg;

    localparam int PIXEL_W = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } merge_state_t;

endpackage

// File: rtl/merge_tiles.sv
// rtl/merge_tiles.sv - reassembles row-major FILTER_SIZE tiles into a SIZE x SIZE image
module merge_tiles
    import cnn_pkg::*;
#(
    parameter int SIZE        = 9,
    parameter int FILTER_SIZE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIXEL_W-1:0]  tile_in [FILTER_SIZE][FILTER_SIZE],
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PIXEL_W-1:0]  image_out [SIZE][SIZE],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [$clog2((SIZE/FILTER_SIZE)*(SIZE/FILTER_SIZE)+1)-1:0] tile_count
);

    localparam int NT     = SIZE / FILTER_SIZE;
    localparam int NTILES = NT * NT;
    localparam int CW     = $clog2(NTILES + 1);

    merge_state_t       state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PIXEL_W-1:0] image_q [SIZE][SIZE];

    logic               xfer;
    logic               last_tile;
    logic [CW-1:0]      tr;
    logic [CW-1:0]      tc;

    // Decode the current tile index into its row/column block position
    always_comb begin
        tr        = count_q / CW'(NT);
        tc        = count_q % CW'(NT);
        last_tile = (count_q == CW'(NTILES - 1));
        xfer      = (state_q == COLLECT) && in_valid;
    end

    // Next-state logic: collect tiles until the image is full, then wait for release
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    if (last_tile) begin
                        state_d = FULL;
                        count_d = CW'(NTILES);
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = COLLECT;
                    count_d = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = '0;
            end
        endcase
    end

    // State and tile counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Image storage: only the pixels of the addressed tile block are written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    image_q[i][j] <= '0;
                end
            end
        end else if (xfer) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    if (tr == CW'(i / FILTER_SIZE) && tc == CW'(j / FILTER_SIZE)) begin
                        image_q[i][j] <= tile_in[i % FILTER_SIZE][j % FILTER_SIZE];
                    end
                end
            end
        end
    end

    assign in_ready   = (state_q == COLLECT);
    assign out_valid  = (state_q == FULL);
    assign image_out  = image_q;
    assign tile_count = count_q;

endmodule

// File: tb/tb_merge_tiles.sv
// tb/tb_merge_tiles.sv - scoreboard bench for merge_tiles
module tb_merge_tiles;
    import cnn_pkg::*;

    localparam int SIZE = 9;
    localparam int FS   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tile_in [FS][FS];
    logic        in_valid;
    logic        in_ready;
    logic [31:0] image_out [SIZE][SIZE];
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  tile_count;

    merge_tiles #(.SIZE(SIZE), .FILTER_SIZE(FS)) dut (
        .clk        (clk),
        .rst        (rst),
        .tile_in    (tile_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .image_out  (image_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .tile_count (tile_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard storage: expected images, counts and arrival cycles
    logic [31:0] exp_img [4][SIZE][SIZE];
    int          exp_cnt [4];
    int          exp_cyc [4];
    int          sb_q [$];
    int          n_exp = 0;

    // Expected pixel value for each stimulus pattern
    // 0: tile t filled with t+1; 1: 100t+10r+c; 2: all zero; 3: pattern 0 with tile 0 = 0xAA
    function automatic logic [31:0] exp_pix(input int mode, input int i, input int j);
        int t;
        t = 3 * (i / 3) + (j / 3);
        case (mode)
            0: return 32'(t + 1);
            1: return 32'(100 * t + 10 * (i % 3) + (j % 3));
            2: return 32'd0;
            default: return (i < 3 && j < 3) ? 32'h0000_00AA : 32'(t + 1);
        endcase
    endfunction

    // Monitor: compare each newly presented image against the head of the scoreboard
    logic prev_ov = 1'b0;
    int   mon_id;
    int   mon_nb;
    int   mon_fi;
    int   mon_fj;
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_image: out_valid rose at cycle %0d, required no pending image", cyc);
            end else begin
                mon_id = sb_q.pop_front();
                mon_nb = 0;
                mon_fi = 0;
                mon_fj = 0;
                for (int i = 0; i < SIZE; i++) begin
                    for (int j = 0; j < SIZE; j++) begin
                        if (image_out[i][j] !== exp_img[mon_id][i][j]) begin
                            if (mon_nb == 0) begin
                                mon_fi = i;
                                mon_fj = j;
                            end
                            mon_nb++;
                        end
                    end
                end
                total++;
                if (mon_nb != 0) begin
                    bad++;
                    $display("FAIL sb_image%0d: %0d pixels differ, [%0d][%0d] actual=%0d required=%0d",
                             mon_id, mon_nb, mon_fi, mon_fj, image_out[mon_fi][mon_fj],
                             exp_img[mon_id][mon_fi][mon_fj]);
                end
                total++;
                if (int'(tile_count) != exp_cnt[mon_id]) begin
                    bad++;
                    $display("FAIL sb_count%0d: actual=%0d required=%0d", mon_id, tile_count, exp_cnt[mon_id]);
                end
                total++;
                if (cyc != exp_cyc[mon_id]) begin
                    bad++;
                    $display("FAIL sb_latency%0d: out_valid rose at cycle %0d required %0d", mon_id, cyc, exp_cyc[mon_id]);
                end
            end
        end
        prev_ov <= out_valid;
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_image(input string name, input int mode);
        int nb;
        int fi;
        int fj;
        nb = 0;
        fi = 0;
        fj = 0;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                if (image_out[i][j] !== exp_pix(mode, i, j)) begin
                    if (nb == 0) begin
                        fi = i;
                        fj = j;
                    end
                    nb++;
                end
            end
        end
        total++;
        if (nb != 0) begin
            bad++;
            $display("FAIL %s: %0d pixels differ, [%0d][%0d] actual=%0d required=%0d",
                     name, nb, fi, fj, image_out[fi][fj], exp_pix(mode, fi, fj));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tile(input int mode, input int t);
        for (int r = 0; r < FS; r++) begin
            for (int c = 0; c < FS; c++) begin
                case (mode)
                    0: tile_in[r][c] = 32'(t + 1);
                    1: tile_in[r][c] = 32'(100 * t + 10 * r + c);
                    2: tile_in[r][c] = 32'h0000_00AA;
                    default: tile_in[r][c] = 32'h0000_DEAD;
                endcase
            end
        end
    endtask

    task automatic send_tile(input int mode, input int t);
        set_tile(mode, t);
        in_valid = 1'b1;
        step();
    endtask

    // Called right after the last transfer edge: the image must be visible at this cycle
    task automatic push_expect(input int mode);
        int id;
        id = n_exp;
        n_exp++;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                exp_img[id][i][j] = exp_pix(mode, i, j);
            end
        end
        exp_cnt[id] = 9;
        exp_cyc[id] = cyc;
        sb_q.push_back(id);
    endtask

    task automatic release_image();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_tile(0, 0);
        step();
        step();
        rst = 1'b0;

        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_tile_count", tile_count, 0);
        check_image("reset_image", 2);

        // Nine back-to-back tiles, tile t = t+1
        for (int t = 0; t < 9; t++) begin
            send_tile(0, t);
            if (t == 3) check("count_after_4", tile_count, 4);
        end
        push_expect(0);

        // Full image held while the consumer stalls; inputs ignored
        set_tile(3, 0);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_in_ready", in_ready, 0);
            check("stall_tile_count", tile_count, 9);
            check_image("stall_image", 0);
        end

        // Release with a tile already offered; it must not land on the release edge
        set_tile(2, 0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_tile_count", tile_count, 0);
        check_image("release_image_kept", 0);
        step();
        in_valid = 1'b0;
        check_image("overwrite_tile0", 3);
        check("overwrite_count", tile_count, 1);

        // Reset in the middle of collection, competing with a transfer
        for (int t = 1; t < 4; t++) send_tile(0, t);
        in_valid = 1'b0;
        check("partial_count", tile_count, 4);
        set_tile(0, 4);
        in_valid = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midreset_count", tile_count, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_valid", out_valid, 0);
        check_image("midreset_image", 2);

        // Nine tiles with in_valid toggling every cycle
        for (int t = 0; t < 9; t++) begin
            send_tile(0, t);
            if (t == 8) push_expect(0);
            in_valid = 1'b0;
            if (t < 8) step();
        end
        step();
        release_image();
        check("gap_release_in_ready", in_ready, 1);

        // Distinct per-pixel data
        for (int t = 0; t < 9; t++) send_tile(1, t);
        push_expect(1);
        in_valid = 1'b0;
        check("pixel_4_7", image_out[4][7], 511);
        step();
        release_image();
        check("final_in_ready", in_ready, 1);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/merge_tiles.md
MERGE_TILES -- requirements
Module: merge_tiles

Interface
REQ-001 Parameter SIZE, default 9: image side length in pixels.
REQ-002 Parameter FILTER_SIZE, default 3: tile side length in pixels; SIZE shall be an integer multiple of FILTER_SIZE.
REQ-003 Derived constant NT = SIZE/FILTER_SIZE (tiles per row/column); NTILES = NT*NT.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 tile_in  input  32 x [FILTER_SIZE][FILTER_SIZE] unpacked array  one tile, pixel [r][c].
REQ-007 in_valid  input  1  tile_in holds a valid tile.
REQ-008 in_ready  output  1  block can accept a tile this cycle.
REQ-009 image_out  output  32 x [SIZE][SIZE] unpacked array  reassembled image.
REQ-010 out_valid  output  1  image_out holds a complete image.
REQ-011 out_ready  input  1  consumer accepts image_out this cycle.
REQ-012 tile_count  output  $clog2(NTILES+1)  number of tiles accepted into the current image.

Function
REQ-013 Two-state FSM: COLLECT and FULL.
REQ-014 in_ready shall be 1 exactly when the state is COLLECT; out_valid shall be 1 exactly when the state is FULL; neither depends combinationally on an input.
REQ-015 A tile transfer occurs on a cycle with in_valid && in_ready.
REQ-016 Tile index t = tile_count at transfer; tile row block tr = t / NT, tile column block tc = t % NT (row-major tile order).
REQ-017 On transfer, image_out[tr*FILTER_SIZE + r][tc*FILTER_SIZE + c] <= tile_in[r][c] for all r, c; all other pixels hold.
REQ-018 On transfer with t < NTILES-1: tile_count increments and the state stays COLLECT.
REQ-019 On transfer with t == NTILES-1: tile_count becomes NTILES and the state goes to FULL; out_valid is asserted on the next cycle with the last tile already visible in image_out (1-cycle latency).
REQ-020 In FULL, in_valid is ignored; image_out and tile_count hold while out_ready is 0.
REQ-021 In FULL with out_ready == 1: the state returns to COLLECT and tile_count becomes 0 on the next edge; image_out retains its old contents until overwritten tile by tile.
REQ-022 A new tile cannot be accepted on the same cycle as image release (in_ready is 0 in FULL); the earliest next transfer is the cycle after release.
REQ-023 in_valid deasserted in COLLECT causes no state change; gaps between tiles of any length are legal.
REQ-024 Pixel values pass through unmodified (no arithmetic, no width change).

Reset
REQ-025 When rst is 1 at a rising edge: state = COLLECT, tile_count = 0, all image_out pixels = 0, out_valid = 0, in_ready = 1 after that edge.
REQ-026 rst has priority over any transfer or release on the same edge; a partially collected image is discarded.

Structure
REQ-027 The FSM state enum and the pixel width constant (32) shall reside in the shared CNN package also used by the tile-splitting block.
REQ-028 Single module; no sub-module. Address decode of tile_count into (tr, tc) shall be computed inside merge_tiles.

Verification
REQ-029 SIZE=9, FILTER_SIZE=3, nine back-to-back tiles, tile t with all pixels = t+1 -> one cycle after the ninth transfer out_valid=1, pixel [i][j] = 3*(i/3)+(j/3)+1, tile_count=9.
REQ-030 Same nine tiles with in_valid toggled 1/0 each cycle -> identical image_out; out_valid rises one cycle after the ninth transfer.
REQ-031 Image complete, out_ready held 0 for 5 cycles while in_valid=1 with pixels 0xDEAD -> image_out unchanged, in_ready=0, tile_count=9 throughout.
REQ-032 out_ready=1 for one cycle in FULL -> next cycle out_valid=0, in_ready=1, tile_count=0; new tile 0 with pixels 0xAA overwrites only rows 0-2, cols 0-2.
REQ-033 rst asserted after 4 tiles -> next cycle tile_count=0, all pixels 0, in_ready=1; nine fresh tiles then produce a complete image.
REQ-034 Tile values with distinct per-pixel data (tile t, pixel [r][c] = 100*t + 10*r + c) -> image_out[4][7] = 100*5 + 10*1 + 1 = 511.
